vga_sync: RTL
=============

// Module: vga_sync
// PURPOSE
//  Upstream timing generator for vga_frame: produces pixel strobe, column/row coordinates and HSYNC/VSYNC
//  for 640x480@60 Hz from the 100 MHz system clock. o_pix_valid/o_col/o_row drive vga_frame
//  i_pix_valid/i_col/i_row; syncs go to the connector, delayed to match vga_frame's 1-cycle registered RGB.
// PARAMETERS
//  H_VISIBLE 640 visible columns | H_FP 16 h front porch | H_SYNC 96 h sync width | H_BP 48 h back porch
//  V_VISIBLE 480 visible rows    | V_FP 10 v front porch | V_SYNC 2 v sync width  | V_BP 33 v back porch
//  PIX_DIV   4   clk cycles per pixel (>=1); H_TOTAL=800, V_TOTAL=525 derived
// PORTS
//  clk            in  1   system clock, 100 MHz
//  rst            in  1   asynchronous reset, active-low
//  o_pix_valid    out 1   one-clk strobe per visible pixel (ROM enable for vga_frame)
//  o_col          out 10  current column 0..H_TOTAL-1
//  o_row          out 10  current row 0..V_TOTAL-1
//  o_hsync        out 1   horizontal sync, active-low, aligned with vga_frame RGB
//  o_vsync        out 1   vertical sync, active-low, aligned with vga_frame RGB
//  o_frame_start  out 1   one-clk pulse when counters enter (0,0)
//  o_frame_cnt    out 16  frames since reset (only with VGA_SYNC_FRAME_CNT_EN)
// BEHAVIOUR
//  - Reset (rst=0, async): div_cnt, h_cnt, v_cnt=0; o_pix_valid=0, o_col=0, o_row=0, o_hsync=1,
//    o_vsync=1, o_frame_start=0, o_frame_cnt=0. Release is synchronous to clk rising edge.
//  - Divider: div_cnt counts 0..PIX_DIV-1, wraps; tick=(div_cnt==PIX_DIV-1). PIX_DIV=1 -> tick every clk.
//  - On tick: h_cnt++; h_cnt==H_TOTAL-1 -> h_cnt=0 and v_cnt++; additionally v_cnt==V_TOTAL-1 -> v_cnt=0.
//    (799,524) -> (0,0) in one tick; counters never exceed TOTAL-1.
//  - Stage 1 (registered, clk after tick): o_col=h_cnt, o_row=v_cnt (held PIX_DIV clks);
//    o_pix_valid=1 for exactly that one clk iff h_cnt<H_VISIBLE && v_cnt<V_VISIBLE; else 0.
//    o_frame_start=1 for that one clk iff new (h_cnt,v_cnt)==(0,0).
//  - Sync: hs_raw=~(h in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]) i.e. 656..751;
//    vs_raw=~(v in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1]) i.e. 490..491.
//    Registered in stage 1 alongside o_col, then delayed one further clk (stage 2) -> o_hsync/o_vsync,
//    matching vga_frame output latency of 1 clk after its inputs.
//  - First pixel after reset release: tick at clk PIX_DIV-1 -> (0,0)->(1,0) counter update; the (0,0)
//    pixel is presented on the first stage-1 update after reset with o_pix_valid=1 and o_frame_start=1.
//  - Reset mid-frame: all state returns to reset values immediately; next frame starts at (0,0); no
//    partial sync pulse is extended (o_hsync/o_vsync forced 1 during reset).
//  - Widths: all compares unsigned 10-bit; parameters must satisfy H_TOTAL<=1024, V_TOTAL<=1024.
// CONFIGURATION
//  VGA_SYNC_FRAME_CNT_EN defined: o_frame_cnt increments (wraps 65535->0) in the clk o_frame_start=1;
//    reset frame (first (0,0) after release) is not counted, so first frame reads 0.
//  Not defined: o_frame_cnt port absent; no counter logic synthesised.
// STRUCTURE
//  - vga_pkg: H_/V_ timing localparams for 640x480, H_TOTAL/V_TOTAL, typedef logic [9:0] coord_t.
//  - Sub-module vga_pix_div: PIX_DIV counter producing tick; rest (counters, decode, 2-stage sync
//    delay) in vga_sync.
// TESTING
//  1 Reset: hold rst=0 20 clks -> o_hsync=o_vsync=1, o_pix_valid=0, o_col=o_row=0 throughout.
//  2 Pixel strobe: PIX_DIV=4, run one line -> exactly 640 o_pix_valid pulses, each 1 clk, 4 clks apart;
//    o_col 0..639 on pulses; line period 3200 clks.
//  3 HSYNC: o_hsync low 96*4=384 clks, falling edge 1 clk after stage-1 o_col==656; period 3200 clks.
//  4 Frame wrap: run to (799,524) -> next update (0,0), o_frame_start pulse; o_vsync low 2 lines
//    (6400 clks) starting row 490; frame period 1,680,000 clks.
//  5 Mid-frame reset: assert rst at row 200 col 300 -> outputs to reset values asynchronously; after release
//    first strobe is (0,0) with o_frame_start=1.
//  6 VGA_SYNC_FRAME_CNT_EN: run 3 frames -> o_frame_cnt 0,1,2 stepping at each o_frame_start; PIX_DIV=1
//    variant: strobes on consecutive clks.

Source files
------------

// File: rtl/vga_pkg.sv
// Timing constants and coordinate type for the 640x480@60 Hz VGA sync generator.
package vga_pkg;
    localparam int unsigned H_VISIBLE = 32'd640;
    localparam int unsigned H_FP      = 32'd16;
    localparam int unsigned H_SYNC    = 32'd96;
    localparam int unsigned H_BP      = 32'd48;
    localparam int unsigned V_VISIBLE = 32'd480;
    localparam int unsigned V_FP      = 32'd10;
    localparam int unsigned V_SYNC    = 32'd2;
    localparam int unsigned V_BP      = 32'd33;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned COORD_W   = 32'd10;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction
endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: tick_o is high for one clk out of every PIX_DIV clks.
module vga_pix_div #(
    parameter int unsigned PIX_DIV = 32'd4
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);
    localparam int unsigned      DIV_W   = (PIX_DIV > 32'd1) ? $clog2(PIX_DIV) : 32'd1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 32'd1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_s;

    // Next divider value, wrapping at PIX_DIV-1.
    always_comb begin
        tick_s = (div_q == DIV_MAX);
        if (tick_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o = tick_s;
endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel strobe, raster coordinates and HSYNC/VSYNC delayed to match vga_frame.
// Optional feature macro: VGA_SYNC_FRAME_CNT_EN adds the o_frame_cnt output.
module vga_sync #(
    parameter int unsigned PIX_DIV   = 32'd4,
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = vga_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_pkg::H_BP,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FP      = vga_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_pkg::V_BP
) (
    input  logic            clk,
    input  logic            rst,
    output logic            o_pix_valid,
    output vga_pkg::coord_t o_col,
    output vga_pkg::coord_t o_row,
    output logic            o_hsync,
    output logic            o_vsync,
    output logic            o_frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [15:0]     o_frame_cnt
`endif
);
    import vga_pkg::*;

    localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 32'd1);
    localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 32'd1);
    localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FP + H_SYNC - 32'd1);
    localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FP + V_SYNC - 32'd1);

    logic   tick_s;
    coord_t h_q, h_d, v_q, v_d;
    coord_t col_q, col_d, row_q, row_d;
    logic   pix_valid_q, pix_valid_d;
    logic   frame_start_q, frame_start_d;
    logic   hs1_q, hs1_d, vs1_q, vs1_d;
    logic   hs2_q, vs2_q;

    vga_pix_div #(.PIX_DIV(PIX_DIV)) u_pix_div (
        .clk_i  (clk),
        .rst_ni (rst),
        .tick_o (tick_s)
    );

    // Raster advance and stage-1 decode of the position being left on this tick.
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        col_d         = col_q;
        row_d         = row_q;
        hs1_d         = hs1_q;
        vs1_d         = vs1_q;
        pix_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        if (tick_s) begin
            col_d         = h_q;
            row_d         = v_q;
            pix_valid_d   = (h_q < H_VIS_C) && (v_q < V_VIS_C);
            frame_start_d = (h_q == '0) && (v_q == '0);
            hs1_d         = ~in_window(h_q, HS_FIRST, HS_LAST);
            vs1_d         = ~in_window(v_q, VS_FIRST, VS_LAST);
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + coord_t'(1);
                end
            end else begin
                h_d = h_q + coord_t'(1);
            end
        end else begin
            pix_valid_d   = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    // Counters, stage-1 outputs, and a second sync stage lining up with vga_frame's RGB register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q           <= '0;
            v_q           <= '0;
            col_q         <= '0;
            row_q         <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            hs2_q         <= 1'b1;
            vs2_q         <= 1'b1;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            hs2_q         <= hs1_q;
            vs2_q         <= vs1_q;
        end
    end

    assign o_pix_valid   = pix_valid_q;
    assign o_col         = col_q;
    assign o_row         = row_q;
    assign o_hsync       = hs2_q;
    assign o_vsync       = vs2_q;
    assign o_frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        first_seen_q, first_seen_d;

    // The first (0,0) after reset opens frame 0 and is not counted.
    always_comb begin
        if (frame_start_d && first_seen_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        first_seen_d = first_seen_q | frame_start_d;
    end

    // Frame counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q  <= 16'd0;
            first_seen_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            first_seen_q <= first_seen_d;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`endif
endmodule
